// File: rtl/mips_dbg_pkg.sv
// Shared definitions for the MIPS debug/execution sequencer: command bytes,
// FSM state encoding and the default end-of-program marker.
package mips_dbg_pkg;

    localparam int unsigned NB_CMD_BYTE = 8;

    localparam logic [NB_CMD_BYTE-1:0] CMD_LOAD  = 8'h4C;  // 'L'
    localparam logic [NB_CMD_BYTE-1:0] CMD_CONT  = 8'h43;  // 'C'
    localparam logic [NB_CMD_BYTE-1:0] CMD_STEP  = 8'h53;  // 'S'
    localparam logic [NB_CMD_BYTE-1:0] CMD_NEXT  = 8'h4E;  // 'N'
    localparam logic [NB_CMD_BYTE-1:0] CMD_RESET = 8'h52;  // 'R'

    localparam logic [31:0] HALT_WORD_DFLT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_RUN       = 3'd2,
        ST_STEP      = 3'd3,
        ST_STEP_EXEC = 3'd4,
        ST_DRAIN     = 3'd5,
        ST_DONE      = 3'd6
    } state_e;

    function automatic logic cmd_hit(
        input logic                   valid,
        input logic [NB_CMD_BYTE-1:0] cmd,
        input logic [NB_CMD_BYTE-1:0] code
    );
        return valid && (cmd == code);
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Instruction-memory program loader: sequential write address, registered
// write strobe/data, and end-of-load detection (HALT word or last address).
module imem_loader
    import mips_dbg_pkg::*;
#(
    parameter int unsigned         NB_ADDR   = 10,
    parameter int unsigned         NB_DATA   = 32,
    parameter logic [NB_DATA-1:0]  HALT_WORD = NB_DATA'(HALT_WORD_DFLT)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_active,
    input  logic               i_wr_valid,
    input  logic [NB_DATA-1:0] i_wr_data,
    output logic               o_imem_we,
    output logic [NB_ADDR-1:0] o_imem_addr,
    output logic [NB_DATA-1:0] o_imem_data,
    output logic               o_done_c
);

    logic [NB_ADDR-1:0] addr_q;
    logic               wr_take;
    logic               addr_full;

    assign wr_take   = i_active && i_wr_valid;
    assign addr_full = (addr_q == '1);

    // The word that ends the load is still written this cycle.
    assign o_done_c  = wr_take && ((i_wr_data == HALT_WORD) || addr_full);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            addr_q      <= '0;
            o_imem_we   <= 1'b0;
            o_imem_addr <= '0;
            o_imem_data <= '0;
        end else begin
            o_imem_we <= wr_take;
            if (i_start) begin
                addr_q <= '0;
            end else if (wr_take) begin
                o_imem_addr <= addr_q;
                o_imem_data <= i_wr_data;
                // Saturate rather than wrap; the next load restarts at 0.
                if (!addr_full) begin
                    addr_q <= addr_q + NB_ADDR'(1);
                end
            end
        end
    end

endmodule

// File: rtl/mips_exec_ctrl.sv
// Execution sequencer for the 5-stage MIPS pipeline: decodes debug command
// bytes into program load, run, single-step, flush and HALT drain control.
module mips_exec_ctrl
    import mips_dbg_pkg::*;
#(
    parameter int unsigned         NB_ADDR   = 10,
    parameter int unsigned         NB_DATA   = 32,
    parameter int unsigned         NB_CMD    = 8,
    parameter int unsigned         NB_CYCLES = 32,
    parameter logic [NB_DATA-1:0]  HALT_WORD = NB_DATA'(HALT_WORD_DFLT),
    parameter int unsigned         N_DRAIN   = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_cmd_valid,
    input  logic [NB_CMD-1:0]    i_cmd,
    input  logic                 i_wr_valid,
    input  logic [NB_DATA-1:0]   i_wr_data,
    input  logic [NB_DATA-1:0]   i_if_instr,
    output logic                 o_imem_we,
    output logic [NB_ADDR-1:0]   o_imem_addr,
    output logic [NB_DATA-1:0]   o_imem_data,
    output logic                 o_if_en,
    output logic                 o_pipe_en,
    output logic                 o_pipe_flush,
    output logic                 o_step_done,
    output logic                 o_halted,
    output logic [NB_CYCLES-1:0] o_cycle_count,
    output logic [2:0]           o_state
);

    localparam int unsigned NB_DRAIN = $clog2(N_DRAIN + 1);

    state_e              state_q;
    state_e              state_d;
    logic [NB_DRAIN-1:0] drain_cnt_q;

    logic cmd_load;
    logic cmd_cont;
    logic cmd_step;
    logic cmd_next;
    logic cmd_reset;
    logic halt_in_if;
    logic ld_done_c;

    logic enter_exec;
    logic load_start;
    logic drain_load;
    logic if_en_d;
    logic pipe_en_d;
    logic flush_d;
    logic step_done_d;
    logic halted_d;

    assign cmd_load   = cmd_hit(i_cmd_valid, 8'(i_cmd), CMD_LOAD);
    assign cmd_cont   = cmd_hit(i_cmd_valid, 8'(i_cmd), CMD_CONT);
    assign cmd_step   = cmd_hit(i_cmd_valid, 8'(i_cmd), CMD_STEP);
    assign cmd_next   = cmd_hit(i_cmd_valid, 8'(i_cmd), CMD_NEXT);
    assign cmd_reset  = cmd_hit(i_cmd_valid, 8'(i_cmd), CMD_RESET);
    assign halt_in_if = (i_if_instr == HALT_WORD);

    assign o_state = state_q;

    imem_loader #(
        .NB_ADDR   (NB_ADDR),
        .NB_DATA   (NB_DATA),
        .HALT_WORD (HALT_WORD)
    ) u_loader (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (load_start),
        .i_active    (state_q == ST_LOAD),
        .i_wr_valid  (i_wr_valid),
        .i_wr_data   (i_wr_data),
        .o_imem_we   (o_imem_we),
        .o_imem_addr (o_imem_addr),
        .o_imem_data (o_imem_data),
        .o_done_c    (ld_done_c)
    );

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; commands outside their accepting states fall through.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_load) begin
                    state_d = ST_LOAD;
                end else if (cmd_cont) begin
                    state_d = ST_RUN;
                end else if (cmd_step) begin
                    state_d = ST_STEP;
                end
            end
            ST_LOAD: begin
                if (ld_done_c) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (o_if_en && halt_in_if) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_STEP: begin
                if (cmd_next) begin
                    state_d = ST_STEP_EXEC;
                end
            end
            ST_STEP_EXEC: begin
                state_d = halt_in_if ? ST_DRAIN : ST_STEP;
            end
            ST_DRAIN: begin
                if (drain_cnt_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (cmd_load) begin
                    state_d = ST_LOAD;
                end else if (cmd_cont) begin
                    state_d = ST_RUN;
                end else if (cmd_step) begin
                    state_d = ST_STEP;
                end else if (cmd_reset) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered control outputs.
    always_comb begin
        if_en_d     = 1'b0;
        pipe_en_d   = 1'b0;
        flush_d     = 1'b0;
        step_done_d = 1'b0;
        halted_d    = 1'b0;
        enter_exec  = 1'b0;
        load_start  = 1'b0;
        drain_load  = 1'b0;

        enter_exec = ((state_q == ST_IDLE) || (state_q == ST_DONE)) &&
                     ((state_d == ST_RUN) || (state_d == ST_STEP));
        load_start = (state_d == ST_LOAD) && (state_q != ST_LOAD);
        drain_load = (state_d == ST_DRAIN) && (state_q != ST_DRAIN);

        flush_d     = enter_exec ||
                      (cmd_reset && ((state_q == ST_IDLE) || (state_q == ST_DONE)));
        step_done_d = (state_q == ST_STEP_EXEC);

        case (state_d)
            ST_RUN: begin
                // First RUN cycle is the flush cycle with enables low.
                if (!enter_exec) begin
                    if_en_d   = 1'b1;
                    pipe_en_d = 1'b1;
                end
            end
            ST_STEP_EXEC: begin
                if_en_d   = 1'b1;
                pipe_en_d = 1'b1;
            end
            ST_DRAIN: pipe_en_d = 1'b1;
            ST_DONE:  halted_d  = 1'b1;
            default: ;
        endcase
    end

    // Registered outputs, drain down-counter and saturating cycle counter.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            o_if_en       <= 1'b0;
            o_pipe_en     <= 1'b0;
            o_pipe_flush  <= 1'b0;
            o_step_done   <= 1'b0;
            o_halted      <= 1'b0;
            o_cycle_count <= '0;
            drain_cnt_q   <= '0;
        end else begin
            o_if_en      <= if_en_d;
            o_pipe_en    <= pipe_en_d;
            o_pipe_flush <= flush_d;
            o_step_done  <= step_done_d;
            o_halted     <= halted_d;

            if (drain_load) begin
                drain_cnt_q <= NB_DRAIN'(N_DRAIN - 1);
            end else if ((state_q == ST_DRAIN) && (drain_cnt_q != '0)) begin
                drain_cnt_q <= drain_cnt_q - NB_DRAIN'(1);
            end

            if (enter_exec) begin
                o_cycle_count <= '0;
            end else if (o_pipe_en && (o_cycle_count != '1)) begin
                o_cycle_count <= o_cycle_count + NB_CYCLES'(1);
            end
        end
    end

endmodule

// File: tb/tb_mips_exec_ctrl.sv
// Directed bench for mips_exec_ctrl: a cycle table for load/run plus
// hand-written step, reset, ignored-command and load-overflow sequences.
module tb_mips_exec_ctrl;

    localparam logic [7:0]  C_L = 8'h4C;
    localparam logic [7:0]  C_C = 8'h43;
    localparam logic [7:0]  C_S = 8'h53;
    localparam logic [7:0]  C_N = 8'h4E;
    localparam logic [7:0]  C_R = 8'h52;
    localparam logic [31:0] H   = 32'hFFFF_FFFF;
    localparam int          NV  = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cmd_valid;
    logic [7:0]  cmd;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic [31:0] if_instr;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_data;
    logic        if_en, pipe_en, pipe_flush, step_done, halted;
    logic [31:0] cycle_count;
    logic [2:0]  state;

    logic        s_cmd_valid;
    logic [7:0]  s_cmd;
    logic        s_wr_valid;
    logic [31:0] s_wr_data;
    logic        s_imem_we;
    logic [1:0]  s_imem_addr;
    logic [31:0] s_imem_data;
    logic        s_if_en, s_pipe_en, s_pipe_flush, s_step_done, s_halted;
    logic [31:0] s_cycle_count;
    logic [2:0]  s_state;

    mips_exec_ctrl dut (
        .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
        .i_wr_valid(wr_valid), .i_wr_data(wr_data), .i_if_instr(if_instr),
        .o_imem_we(imem_we), .o_imem_addr(imem_addr), .o_imem_data(imem_data),
        .o_if_en(if_en), .o_pipe_en(pipe_en), .o_pipe_flush(pipe_flush),
        .o_step_done(step_done), .o_halted(halted),
        .o_cycle_count(cycle_count), .o_state(state)
    );

    mips_exec_ctrl #(.NB_ADDR(2)) dut_small (
        .i_clk(clk), .i_rst(rst), .i_cmd_valid(s_cmd_valid), .i_cmd(s_cmd),
        .i_wr_valid(s_wr_valid), .i_wr_data(s_wr_data), .i_if_instr(32'h0),
        .o_imem_we(s_imem_we), .o_imem_addr(s_imem_addr), .o_imem_data(s_imem_data),
        .o_if_en(s_if_en), .o_pipe_en(s_pipe_en), .o_pipe_flush(s_pipe_flush),
        .o_step_done(s_step_done), .o_halted(s_halted),
        .o_cycle_count(s_cycle_count), .o_state(s_state)
    );

    logic [82:0] act_b;
    assign act_b = {imem_we, imem_addr, imem_data, if_en, pipe_en, pipe_flush,
                    step_done, halted, state, cycle_count};

    typedef struct {
        logic        cv;
        logic [7:0]  c;
        logic        wv;
        logic [31:0] wd;
        logic [31:0] ins;
        logic [82:0] exp;
    } vec_t;

    vec_t vecs [NV];
    int   n_chk = 0;
    int   n_err = 0;
    int   pe_n, sd_n, dbl, n_wr, waited;
    logic prev_pe;

    function automatic vec_t mk(
        input logic cv, input logic [7:0] c, input logic wv, input logic [31:0] wd,
        input logic [31:0] ins, input logic we, input logic [9:0] a, input logic [31:0] d,
        input logic ie, input logic pe, input logic fl, input logic sd, input logic h,
        input logic [2:0] st, input logic [31:0] cc
    );
        vec_t v;
        v.cv  = cv;
        v.c   = c;
        v.wv  = wv;
        v.wd  = wd;
        v.ins = ins;
        v.exp = {we, a, d, ie, pe, fl, sd, h, st, cc};
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c);
        cmd_valid = 1'b1;
        cmd       = c;
        tick();
        cmd_valid = 1'b0;
        cmd       = 8'h00;
    endtask

    task automatic write_word(input logic [31:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic step_sample();
        if (pipe_en) pe_n++;
        if (pipe_en && prev_pe) dbl++;
        if (step_done) sd_n++;
        prev_pe = pipe_en;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        // Load three words (one with a concurrent, dropped command), then run to HALT.
        vecs[0]  = mk(1, C_L, 0, 32'h0,        32'h0, 0, 10'd0, 32'h0,        0, 0, 0, 0, 0, 3'd1, 32'd0);
        vecs[1]  = mk(0, 8'h0, 1, 32'h20010005, 32'h0, 1, 10'd0, 32'h20010005, 0, 0, 0, 0, 0, 3'd1, 32'd0);
        vecs[2]  = mk(0, 8'h0, 0, 32'h0,        32'h0, 0, 10'd0, 32'h20010005, 0, 0, 0, 0, 0, 3'd1, 32'd0);
        vecs[3]  = mk(1, C_C, 1, 32'h20020003, 32'h0, 1, 10'd1, 32'h20020003, 0, 0, 0, 0, 0, 3'd1, 32'd0);
        vecs[4]  = mk(0, 8'h0, 1, H,            32'h0, 1, 10'd2, H,            0, 0, 0, 0, 0, 3'd0, 32'd0);
        vecs[5]  = mk(0, 8'h0, 0, 32'h0,        32'h0, 0, 10'd2, H,            0, 0, 0, 0, 0, 3'd0, 32'd0);
        vecs[6]  = mk(1, C_N, 0, 32'h0,        32'h0, 0, 10'd2, H,            0, 0, 0, 0, 0, 3'd0, 32'd0);
        vecs[7]  = mk(1, C_C, 0, 32'h0,        32'h0, 0, 10'd2, H,            0, 0, 1, 0, 0, 3'd2, 32'd0);
        vecs[8]  = mk(0, 8'h0, 0, 32'h0,        32'h0, 0, 10'd2, H,            1, 1, 0, 0, 0, 3'd2, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            vecs[8+k] = mk(0, 8'h0, 0, 32'h0, 32'h0, 0, 10'd2, H, 1, 1, 0, 0, 0, 3'd2, 32'(k));
        end
        vecs[14] = mk(0, 8'h0, 0, 32'h0, H,     0, 10'd2, H, 0, 1, 0, 0, 0, 3'd5, 32'd6);
        vecs[15] = mk(1, C_C, 0, 32'h0, H,     0, 10'd2, H, 0, 1, 0, 0, 0, 3'd5, 32'd7);
        vecs[16] = mk(0, 8'h0, 0, 32'h0, 32'h0, 0, 10'd2, H, 0, 1, 0, 0, 0, 3'd5, 32'd8);
        vecs[17] = mk(0, 8'h0, 0, 32'h0, 32'h0, 0, 10'd2, H, 0, 1, 0, 0, 0, 3'd5, 32'd9);
        vecs[18] = mk(0, 8'h0, 0, 32'h0, 32'h0, 0, 10'd2, H, 0, 0, 0, 0, 1, 3'd6, 32'd10);
        vecs[19] = mk(1, C_N, 0, 32'h0, 32'h0, 0, 10'd2, H, 0, 0, 0, 0, 1, 3'd6, 32'd10);

        rst         = 1'b0;
        cmd_valid   = 1'b0;
        cmd         = 8'h00;
        wr_valid    = 1'b0;
        wr_data     = 32'h0;
        if_instr    = 32'h0;
        s_cmd_valid = 1'b0;
        s_cmd       = 8'h00;
        s_wr_valid  = 1'b0;
        s_wr_data   = 32'h0;
        repeat (2) tick();
        chk("reset_state", 128'(act_b), 128'(0));
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            cmd_valid = vecs[i].cv;
            cmd       = vecs[i].c;
            wr_valid  = vecs[i].wv;
            wr_data   = vecs[i].wd;
            if_instr  = vecs[i].ins;
            tick();
            chk($sformatf("vec%0d", i), 128'(act_b), 128'(vecs[i].exp));
        end
        cmd_valid = 1'b0;
        wr_valid  = 1'b0;
        if_instr  = 32'h0;

        // Restart from DONE into single-step mode.
        send(C_S);
        chk("step_entry_state",  128'(state), 128'(3));
        chk("step_entry_flush",  128'(pipe_flush), 128'(1));
        chk("step_entry_halted", 128'(halted), 128'(0));
        chk("step_entry_count",  128'(cycle_count), 128'(0));
        pe_n    = 0;
        sd_n    = 0;
        dbl     = 0;
        prev_pe = 1'b0;
        for (int k = 0; k < 3; k++) begin
            send(C_N);
            chk("step_exec_state", 128'(state), 128'(4));
            step_sample();
            for (int j = 0; j < 4; j++) begin
                tick();
                step_sample();
            end
        end
        chk("step_pe_pulses",   128'(pe_n), 128'(3));
        chk("step_done_pulses", 128'(sd_n), 128'(3));
        chk("step_pe_single",   128'(dbl), 128'(0));
        chk("step_count",       128'(cycle_count), 128'(3));
        chk("step_back_state",  128'(state), 128'(3));

        // HALT fetched during a step: drain, step_done still pulses.
        send(C_N);
        if_instr = H;
        tick();
        if_instr = 32'h0;
        chk("step_halt_state", 128'(state), 128'(5));
        chk("step_halt_done",  128'(step_done), 128'(1));
        chk("step_halt_en",    128'({if_en, pipe_en}), 128'(2'b01));
        waited = 0;
        while (!halted && waited < 10) begin
            tick();
            waited++;
        end
        chk("step_halt_reached", 128'(halted), 128'(1));
        chk("step_halt_count",   128'(cycle_count), 128'(8));

        // 'R' from DONE and from IDLE: flush pulse, land in IDLE.
        send(C_R);
        chk("done_r_state",  128'({state, pipe_flush, halted}), 128'({3'd0, 1'b1, 1'b0}));
        send(C_R);
        chk("idle_r_state",  128'({state, pipe_flush}), 128'({3'd0, 1'b1}));
        tick();
        chk("idle_r_pulse",  128'(pipe_flush), 128'(0));

        // Reset in the middle of a load, then reload from address 0.
        send(C_L);
        write_word(32'h0000_0011);
        write_word(32'h0000_0022);
        write_word(32'h0000_0033);
        rst = 1'b0;
        tick();
        chk("rst_midload", 128'(act_b), 128'(0));
        rst = 1'b1;
        send(C_L);
        write_word(32'h0000_00AB);
        chk("reload_addr0", 128'({imem_we, imem_addr, imem_data, state}),
            128'({1'b1, 10'd0, 32'h0000_00AB, 3'd1}));

        // Load overflow on a 4-word memory: the fifth word is dropped.
        s_cmd_valid = 1'b1;
        s_cmd       = C_L;
        tick();
        s_cmd_valid = 1'b0;
        n_wr        = 0;
        for (int i = 0; i < 5; i++) begin
            s_wr_valid = 1'b1;
            s_wr_data  = 32'h100 + 32'(i);
            tick();
            if (s_imem_we) begin
                chk($sformatf("ovf_addr%0d", n_wr), 128'({s_imem_addr, s_imem_data}),
                    128'({2'(n_wr), 32'h100 + 32'(n_wr)}));
                n_wr++;
            end
        end
        s_wr_valid = 1'b0;
        chk("ovf_writes", 128'(n_wr), 128'(4));
        chk("ovf_state",  128'(s_state), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
